// File: rtl/display_scan_mux.sv
// Purpose: time-multiplexed 7-segment driver with tear-free double-buffered digits, leading-zero blanking and per-digit blink.
// Latency: hex/dig_sel registered, 1 cycle after idx/shadow/phase; new numbers shown from the frame after the next wrap.
// Backpressure: none; load is always accepted, and the last load before a wrap wins.
module display_scan_mux #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   numbers,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_en,
    output logic [6:0]            hex,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0]     PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [BW-1:0]     BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [DIGITS-1:0] SEL_ONE   = DIGITS'(1);

    logic [PW-1:0]         presc;
    logic                  tick;
    logic                  wrap_tick;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         bcnt;
    logic                  phase;
    logic                  pending;
    logic [4*DIGITS-1:0]   staging;
    logic [4*DIGITS-1:0]   shadow;
    logic [3:0]            digit_code [DIGITS];
    logic [DIGITS-1:0]     lz_blank;
    logic                  blank_now;

    // Segment patterns, active low, one per digit code; codes 11..15 are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001101;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            4'd10:   seg = 7'b1111110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign tick      = (presc == PRESC_MAX);
    assign wrap_tick = tick && (idx == IDX_MAX);

    // Slot prescaler, digit index scan and the end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            frame_done <= wrap_tick;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Blink phase flips every BLINK_DIV scan ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            if (bcnt == BLINK_MAX) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Double buffer: loads land in staging, shadow only changes at a frame wrap so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '1;
            shadow  <= '1;
            pending <= 1'b0;
        end else begin
            if (load) begin
                staging <= numbers;
            end
            if (wrap_tick) begin
                pending <= 1'b0;
                if (load) begin
                    shadow <= numbers;
                end else if (pending) begin
                    shadow <= staging;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Split shadow into digits and mark digits covered by a run of leading zeros from the top.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_code[i] = shadow[4*i +: 4];
        end
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero && (digit_code[i] == 4'h0);
            lz_blank[i] = all_zero;
        end
    end

    assign blank_now = (blank_lz && lz_blank[idx]) || (phase && blink_en[idx]);

    // Registered segment and digit-select outputs, updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex     <= 7'b1111111;
            dig_sel <= '1;
        end else begin
            hex     <= blank_now ? 7'b1111111 : seg_decode(digit_code[idx]);
            dig_sel <= ~(SEL_ONE << idx);
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux with DIGITS=4, SCAN_DIV=4, BLINK_DIV=2.
// Expected frames are pushed to a queue as stimulus is applied and popped per digit slot.
// Each frame is sampled in the second cycle of every 4-cycle digit slot.
module tb_display_scan_mux;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] numbers = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_en = 4'b0000;
    logic [6:0]  hex;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    // Each entry is {dig_sel, hex} for one digit slot, slot 0 first.
    logic [10:0] exp_q[$];

    display_scan_mux #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .numbers(numbers),
        .blank_lz(blank_lz),
        .blink_en(blink_en),
        .hex(hex),
        .dig_sel(dig_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001101;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            4'd10:   return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    // Frames stay aligned to reset: with 2 ticks per blink half-period and 4 slots per
    // frame, blink phase is 0 during slots 0-1 and 1 during slots 2-3 of every frame.
    task automatic push_frame(input logic [15:0] data, input logic lz, input logic [3:0] blink);
        logic [10:0] ent [4];
        logic        zero_run;
        zero_run = 1'b1;
        for (int d = 3; d >= 0; d--) begin
            logic [3:0] c;
            logic [3:0] sel;
            logic       ph;
            logic       blank;
            c        = data[4*d +: 4];
            zero_run = zero_run && (c == 4'h0);
            ph       = (d >= 2);
            blank    = (lz && (d >= 1) && zero_run) || (ph && blink[d]);
            sel      = 4'b0001 << d;
            sel      = ~sel;
            ent[d]   = {sel, blank ? 7'b1111111 : ref_seg(c)};
        end
        for (int d = 0; d < 4; d++) begin
            exp_q.push_back(ent[d]);
        end
    endtask

    // Waits for the end-of-frame pulse; returns at the sample just after it.
    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_frame_done: no pulse within 40 cycles, required one");
        end
    endtask

    // Observes one frame (15 cycles after frame_done), optionally pulsing load at cycles at1/at2.
    // Cycle 15 is the wrap tick of this frame.
    task automatic capture_frame(input string name, input int at1, input logic [15:0] v1,
                                 input int at2, input logic [15:0] v2);
        logic [10:0] e;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == at1) begin
                load = 1'b1;
                numbers = v1;
            end else if (k == at2) begin
                load = 1'b1;
                numbers = v2;
            end else begin
                load = 1'b0;
            end
            if (k % 4 == 2) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s slot%0d: no expected entry queued", name, k / 4);
                end else begin
                    e = exp_q.pop_front();
                    if ({dig_sel, hex} !== e) begin
                        failures++;
                        $display("FAIL %s slot%0d: dig_sel/hex got %b/%b required %b/%b",
                                 name, k / 4, dig_sel, hex, e[10:7], e[6:0]);
                    end
                end
                checks++;
                if (frame_done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s slot%0d frame_done: got %b required 0", name, k / 4, frame_done);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (hex !== 7'b1111111 || dig_sel !== 4'b1111 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL %s: hex/dig_sel/frame_done got %b/%b/%b required 1111111/1111/0",
                     name, hex, dig_sel, frame_done);
        end
    endtask

    task automatic check_first_edge(input string name);
        checks++;
        if (dig_sel !== 4'b1110 || hex !== 7'b1111111) begin
            failures++;
            $display("FAIL %s: dig_sel/hex got %b/%b required 1110/1111111", name, dig_sel, hex);
        end
    endtask

    task automatic test_reset();
        int n;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_first_edge("reset_first_edge");
        wait_frame();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) break;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL frame_period: got %0d cycles required 16", n);
        end
        push_frame(16'hFFFF, 1'b0, 4'b0000);
        capture_frame("idle_scan", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_load_midframe();
        wait_frame();
        push_frame(16'hFFFF, 1'b0, 4'b0000);
        capture_frame("no_tear", 5, 16'h1234, -1, 16'h0);
        wait_frame();
        push_frame(16'h1234, 1'b0, 4'b0000);
        capture_frame("load_1234", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_reload_lz();
        blank_lz = 1'b1;
        wait_frame();
        push_frame(16'h1234, 1'b1, 4'b0000);
        capture_frame("reload_hold", 3, 16'h1111, 9, 16'h0A05);
        wait_frame();
        push_frame(16'h0A05, 1'b1, 4'b0000);
        capture_frame("lz_on_0a05", -1, 16'h0, -1, 16'h0);
        blank_lz = 1'b0;
        wait_frame();
        push_frame(16'h0A05, 1'b0, 4'b0000);
        capture_frame("lz_off_0a05", -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_zero();
        blank_lz = 1'b1;
        wait_frame();
        push_frame(16'h0A05, 1'b1, 4'b0000);
        capture_frame("pre_zero", 9, 16'h0000, -1, 16'h0);
        wait_frame();
        push_frame(16'h0000, 1'b1, 4'b0000);
        capture_frame("lz_all_zero", -1, 16'h0, -1, 16'h0);
        blank_lz = 1'b0;
    endtask

    task automatic test_blink();
        blink_en = 4'b0101;
        wait_frame();
        push_frame(16'h0000, 1'b0, 4'b0101);
        capture_frame("blink_0101_zero", 7, 16'h1234, -1, 16'h0);
        wait_frame();
        push_frame(16'h1234, 1'b0, 4'b0101);
        capture_frame("blink_0101", -1, 16'h0, -1, 16'h0);
        blink_en = 4'b1010;
        wait_frame();
        push_frame(16'h1234, 1'b0, 4'b1010);
        capture_frame("blink_1010", -1, 16'h0, -1, 16'h0);
        blink_en = 4'b0000;
    endtask

    task automatic test_wrap_load_reset();
        wait_frame();
        push_frame(16'h1234, 1'b0, 4'b0000);
        capture_frame("pre_wrap_load", 15, 16'h9876, -1, 16'h0);
        wait_frame();
        push_frame(16'h9876, 1'b0, 4'b0000);
        capture_frame("wrap_load_9876", -1, 16'h0, -1, 16'h0);
        // Queue a pending update mid-frame, then reset before it can reach the display.
        wait_frame();
        repeat (3) @(negedge clk);
        load = 1'b1;
        numbers = 16'h5555;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midframe_reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_first_edge("midframe_reset_first_edge");
        wait_frame();
        push_frame(16'hFFFF, 1'b0, 4'b0000);
        capture_frame("after_reset_blank", -1, 16'h0, -1, 16'h0);
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_reload_lz();
        test_zero();
        test_blink();
        test_wrap_load_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
